instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch-stage initiator for the instruction memory. Holds the program counter, drives `ins_address` to the combinational instruction memory, and registers the returned `ins_out` word into the IF/ID pipeline register. Handles decode-stage stall, flush and branch/jump redirect. Stops cleanly on a halt request or an out-of-range fetch address.

## Interface
- `RESET_PC`, 32'd0: PC value loaded on reset.
- `MEM_DEPTH`, 64: number of addressable instruction-memory locations; legal fetch addresses are 0..MEM_DEPTH-1.
- `PC_STEP`, 32'd4: sequential PC increment.
- `clk`  input  1: single clock, rising-edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `ins_address`  output  32: fetch address to instruction memory; equals `pc` combinationally.
- `ins_out`  input  32: instruction word returned by memory in the same cycle.
- `stall`  input  1: hold PC and IF/ID register.
- `flush`  input  1: squash the IF/ID contents (insert bubble).
- `redirect`  input  1: branch taken or jump; load `redirect_target`.
- `redirect_target`  input  32: new PC on redirect.
- `halt_req`  input  1: stop fetching after the current cycle.
- `if_id_instr`  output  32: registered instruction.
- `if_id_pc_plus4`  output  32: registered fetch PC + PC_STEP.
- `if_id_valid`  output  1: IF/ID contents are a real instruction.
- `fetch_fault`  output  1: sticky; an out-of-range address was reached.
- `halted`  output  1: high in HALTED state.
- `fetch_count`  output  16: count of instructions captured with valid=1; wraps at 16'hFFFF->0.

## Operation
- States:
  - BOOT: entered on reset; lasts exactly one cycle with no capture; goes to RUN.
  - RUN: normal fetching.
  - HALTED: terminal until reset.
- Reset values: `pc`=RESET_PC, `if_id_instr`=0, `if_id_pc_plus4`=0, `if_id_valid`=0, `fetch_fault`=0, `halted`=0, `fetch_count`=0, state=BOOT.
- RUN, per rising edge, in priority order:
  1. **redirect**: `pc`<=`redirect_target`; `if_id_valid`<=0, because the fetched word is wrong-path. Redirect overrides stall and flush.
  2. **stall**:
     - `pc` holds.
     - If `flush` is also high, `if_id_valid`<=0; otherwise IF/ID holds.
  3. **flush alone**: `pc`<=`pc`+PC_STEP; `if_id_valid`<=0.
  4. **Sequential**: `if_id_instr`<=`ins_out`, `if_id_pc_plus4`<=`pc`+PC_STEP, `if_id_valid`<=1, `pc`<=`pc`+PC_STEP.
- Range check in RUN, evaluated before cases 1-4:
  - Trigger: the current `pc` >= MEM_DEPTH.
  - Response: no capture; `if_id_valid`<=0; `fetch_fault`<=1; state<=HALTED.
  - A redirect in the same cycle is ignored.
- Halt:
  - If `halt_req` is high in RUN, that cycle's capture still follows the rules above.
  - Next state is HALTED.
- HALTED:
  - `pc` and `if_id_instr` freeze; `if_id_valid`<=0; `halted`=1.
  - All of `stall`, `flush`, `redirect` are ignored.
- PC arithmetic: 32-bit unsigned, wraps modulo 2^32. Targets are not alignment-checked.
- `fetch_count` increments on each edge where `if_id_valid` is loaded with 1.

## Timing
- `ins_address` changes only after a rising edge or reset; there is no combinational path from the control inputs to `ins_address`.
- Fetch latency: the word at `pc` in cycle N appears on `if_id_instr` after edge N+1 (one cycle).
- After reset deassertion:
  - First edge: BOOT->RUN.
  - Second edge: word at RESET_PC is captured; `if_id_valid`=1.
- Redirect asserted in cycle N:
  - After edge N: `pc`=target, with one bubble.
  - Target instruction is valid after edge N+1.
- Asynchronous reset mid-operation: all outputs return to reset values immediately. The in-flight instruction is discarded and not counted.
- Control inputs are sampled only at the rising edge and must be stable around it.

## Test plan
- **Reset/boot**:
  - Memory model: addr0=0x34820801, addr4=0x00621002.
  - Release reset; after edge 2, `if_id_instr`=0x34820801, `if_id_pc_plus4`=4, valid=1.
  - After edge 3, `if_id_instr`=0x00621002 and `fetch_count`=2.
- **Stall**: assert stall for 3 cycles at pc=8.
  - `ins_address` stays 8 and IF/ID holds.
  - On release, the word at 8 is captured; `fetch_count` is unchanged during the stall.
- **Redirect**:
  - At pc=12, redirect=1, target=32, with stall=1 also asserted.
  - Next `ins_address`=32; valid=0 for one cycle; then the word at 32 is captured with `if_id_pc_plus4`=36.
- **Flush+stall**: both high at pc=16.
  - `pc` holds at 16; valid=0.
  - Next normal cycle captures the word at 16.
- **Fault**: redirect to 60 (MEM_DEPTH=64).
  - Words at 60 are captured; then pc=64 raises `fetch_fault`=1, `halted`=1, valid=0.
  - All further inputs are ignored until reset.
- **Async reset mid-run**: pulse `reset_n` low between edges at pc=20.
  - All outputs read 0 immediately, including `fetch_count`.
  - `ins_address`=RESET_PC; the boot sequence repeats.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage: PC, IF/ID register, stall/flush/redirect, halt and range fault
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          MEM_DEPTH = 64,
    parameter logic [31:0] PC_STEP   = 32'd4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] ins_address,
    input  logic [31:0] ins_out,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [15:0] count_q, count_d;
    logic [31:0] pc_next;

    assign pc_next = pc_q + PC_STEP;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        fault_d = fault_q;
        count_d = count_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                // Out-of-range fetch wins over everything, including redirect.
                if (pc_q >= 32'(MEM_DEPTH)) begin
                    valid_d = 1'b0;
                    fault_d = 1'b1;
                    state_d = HALTED;
                end else begin
                    if (redirect) begin
                        pc_d    = redirect_target;
                        valid_d = 1'b0;
                    end else if (stall) begin
                        if (flush) valid_d = 1'b0;
                    end else if (flush) begin
                        pc_d    = pc_next;
                        valid_d = 1'b0;
                    end else begin
                        instr_d = ins_out;
                        pc4_d   = pc_next;
                        valid_d = 1'b1;
                        pc_d    = pc_next;
                        count_d = count_q + 16'd1;
                    end
                    if (halt_req) state_d = HALTED;
                end
            end
            HALTED: valid_d = 1'b0;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign ins_address    = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc4_q;
    assign if_id_valid    = valid_q;
    assign fetch_fault    = fault_q;
    assign halted         = (state_q == HALTED);
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] ins_address;
    logic [31:0] ins_out;
    logic        stall, flush, redirect, halt_req;
    logic [31:0] redirect_target;
    logic [31:0] if_id_instr, if_id_pc_plus4;
    logic        if_id_valid, fetch_fault, halted;
    logic [15:0] fetch_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ins_address    (ins_address),
        .ins_out        (ins_out),
        .stall          (stall),
        .flush          (flush),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .halt_req       (halt_req),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .fetch_fault    (fetch_fault),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    // Instruction memory: two fixed words, otherwise 0xA000_0000 | address.
    always_comb begin
        case (ins_address)
            32'd0:   ins_out = 32'h3482_0801;
            32'd4:   ins_out = 32'h0062_1002;
            default: ins_out = 32'hA000_0000 | ins_address;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                             input logic [31:0] pc4, input logic valid, input logic [15:0] cnt,
                             input logic hlt, input logic flt);
        chk({tag, ".addr"},  ins_address, addr);
        chk({tag, ".instr"}, if_id_instr, instr);
        chk({tag, ".pc4"},   if_id_pc_plus4, pc4);
        chk({tag, ".valid"}, 32'(if_id_valid), 32'(valid));
        chk({tag, ".count"}, 32'(fetch_count), 32'(cnt));
        chk({tag, ".halted"}, 32'(halted), 32'(hlt));
        chk({tag, ".fault"}, 32'(fetch_fault), 32'(flt));
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        #2;
        chk_state("reset", 32'd0, 32'd0, 32'd0, 1'b0, 16'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
        halt_req = 1'b0; redirect_target = 32'd0;
        edge1;
        do_reset;

        // Boot: one dead cycle, then sequential capture
        edge1; chk_state("boot",  32'd0, 32'd0, 32'd0, 1'b0, 16'd0, 1'b0, 1'b0);
        edge1; chk_state("cap0",  32'd4, 32'h3482_0801, 32'd4, 1'b1, 16'd1, 1'b0, 1'b0);
        edge1; chk_state("cap4",  32'd8, 32'h0062_1002, 32'd8, 1'b1, 16'd2, 1'b0, 1'b0);

        // Stall three cycles at pc=8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge1; chk_state("stall", 32'd8, 32'h0062_1002, 32'd8, 1'b1, 16'd2, 1'b0, 1'b0);
        end
        stall = 1'b0;
        edge1; chk_state("cap8",  32'd12, 32'hA000_0008, 32'd12, 1'b1, 16'd3, 1'b0, 1'b0);

        // Redirect with stall at pc=12
        redirect = 1'b1; stall = 1'b1; redirect_target = 32'd32;
        edge1; chk_state("redir", 32'd32, 32'hA000_0008, 32'd12, 1'b0, 16'd3, 1'b0, 1'b0);
        redirect = 1'b0; stall = 1'b0;
        edge1; chk_state("cap32", 32'd36, 32'hA000_0020, 32'd36, 1'b1, 16'd4, 1'b0, 1'b0);

        // Flush + stall at pc=16
        redirect = 1'b1; redirect_target = 32'd16;
        edge1; chk_state("redir16", 32'd16, 32'hA000_0020, 32'd36, 1'b0, 16'd4, 1'b0, 1'b0);
        redirect = 1'b0; stall = 1'b1; flush = 1'b1;
        edge1; chk_state("flst",  32'd16, 32'hA000_0020, 32'd36, 1'b0, 16'd4, 1'b0, 1'b0);
        stall = 1'b0; flush = 1'b0;
        edge1; chk_state("cap16", 32'd20, 32'hA000_0010, 32'd20, 1'b1, 16'd5, 1'b0, 1'b0);

        // Asynchronous reset between edges at pc=20
        #2;
        do_reset;
        edge1; chk_state("boot2", 32'd0, 32'd0, 32'd0, 1'b0, 16'd0, 1'b0, 1'b0);
        edge1; chk_state("cap0b", 32'd4, 32'h3482_0801, 32'd4, 1'b1, 16'd1, 1'b0, 1'b0);

        // Flush alone advances pc and inserts a bubble
        flush = 1'b1;
        edge1; chk_state("flush", 32'd8, 32'h3482_0801, 32'd4, 1'b0, 16'd1, 1'b0, 1'b0);
        flush = 1'b0; halt_req = 1'b1;
        edge1; chk_state("halt",  32'd12, 32'hA000_0008, 32'd12, 1'b1, 16'd2, 1'b1, 1'b0);
        halt_req = 1'b0; redirect = 1'b1; redirect_target = 32'd40;
        edge1; chk_state("halted", 32'd12, 32'hA000_0008, 32'd12, 1'b0, 16'd2, 1'b1, 1'b0);
        redirect = 1'b0;

        // Range fault after redirect to 60
        #2;
        do_reset;
        edge1; chk_state("boot3", 32'd0, 32'd0, 32'd0, 1'b0, 16'd0, 1'b0, 1'b0);
        redirect = 1'b1; redirect_target = 32'd60;
        edge1; chk_state("redir60", 32'd60, 32'd0, 32'd0, 1'b0, 16'd0, 1'b0, 1'b0);
        redirect = 1'b0;
        edge1; chk_state("cap60", 32'd64, 32'hA000_003C, 32'd64, 1'b1, 16'd1, 1'b0, 1'b0);
        redirect = 1'b1; redirect_target = 32'd0;
        edge1; chk_state("fault", 32'd64, 32'hA000_003C, 32'd64, 1'b0, 16'd1, 1'b1, 1'b1);
        stall = 1'b1; flush = 1'b1;
        edge1; chk_state("dead",  32'd64, 32'hA000_003C, 32'd64, 1'b0, 16'd1, 1'b1, 1'b1);
        redirect = 1'b0; stall = 1'b0; flush = 1'b0;
        edge1; chk_state("dead2", 32'd64, 32'hA000_003C, 32'd64, 1'b0, 16'd1, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
